// File: rtl/mvma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvma_pkg
//  Description : Shared constants and types for the MVMA stream feeder.
//                K        - matrix dimension
//                DW / OW  - operand / result widths
//                FL       - operand frame length (M, then B, then X)
//  Revision    : 1.0 - initial release
// ============================================================================
package mvma_pkg;
  localparam int K  = 4;
  localparam int DW = 8;
  localparam int OW = 16;
  localparam int FL = K * K + 2 * K;
  localparam int AW = $clog2(FL);
  localparam int KW = $clog2(K);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} feeder_state_t;

  typedef logic signed [DW-1:0] operand_t;
  typedef logic signed [OW-1:0] result_t;
endpackage
`default_nettype wire

// File: rtl/mvma_operand_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mvma_operand_buf
//  Description : FL x DW operand register file, one synchronous write port
//                and one combinational read port. Not reset, so a frame
//                survives a reset and can be resent.
//  Ports       : clk      - clock
//                we_i     - write enable
//                waddr_i  - write index (out-of-range indices are dropped)
//                wdata_i  - write data
//                raddr_i  - read index
//                rdata_o  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module mvma_operand_buf
  import mvma_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  operand_t mem_q [FL];

  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < FL)) begin
      mem_q[waddr_i] <= operand_t'(wdata_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/mvma_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mvma_stream_feeder
//  Description : Host-side feeder for the KxK matrix-vector-multiply-add
//                accelerator. Streams a stored operand frame (M row-major,
//                B, X) over a valid/ready master port, then collects K
//                results plus overflow flags over a valid/ready slave port.
//  Ports       : clk, reset (async, active-low)
//                wr_en/wr_addr/wr_data  - host operand writes (IDLE/DONE only)
//                start                  - send request (IDLE/DONE only)
//                stall_tx / stall_rx    - transmit / receive throttles
//                m_valid/m_ready/m_data - operand stream out
//                r_valid/r_ready/r_data/r_ovf - result stream in
//                rd_addr/rd_data/rd_ovf - result readback
//                busy (SEND or RECV), done (DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
module mvma_stream_feeder
  import mvma_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          stall_tx,
  input  logic          stall_rx,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  input  logic          r_valid,
  output logic          r_ready,
  input  logic [OW-1:0] r_data,
  input  logic          r_ovf,
  input  logic [KW-1:0] rd_addr,
  output logic [OW-1:0] rd_data,
  output logic          rd_ovf,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] TX_LAST = AW'(FL - 1);
  localparam logic [KW-1:0] RX_LAST = KW'(K - 1);

  feeder_state_t state_q, state_d;
  logic [AW-1:0] tx_cnt_q, tx_cnt_d;
  logic [KW-1:0] rx_cnt_q, rx_cnt_d;
  logic          m_valid_q, m_valid_d;
  result_t       res_q [K];
  result_t       res_d [K];
  logic [K-1:0]  ovf_q, ovf_d;

  logic tx_hs;
  logic rx_hs;
  logic host_ok;

  assign host_ok = (state_q == IDLE) || (state_q == DONE);
  assign tx_hs   = m_valid_q && m_ready;
  assign r_ready = (state_q == RECV) && !stall_rx;
  assign rx_hs   = r_valid && r_ready;

  mvma_operand_buf u_buf (
    .clk     (clk),
    .we_i    (wr_en && host_ok),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (tx_cnt_q),
    .rdata_o (m_data)
  );

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    m_valid_d = 1'b0;
    res_d     = res_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND;
          tx_cnt_d = '0;
        end
      end

      SEND: begin
        if (tx_hs) begin
          if (tx_cnt_q == TX_LAST) begin
            // Last byte accepted: m_valid falls, counter holds (saturates).
            state_d  = RECV;
            rx_cnt_d = '0;
          end else begin
            tx_cnt_d  = tx_cnt_q + AW'(1);
            m_valid_d = !stall_tx;
          end
        end else begin
          // A pending offer is never withdrawn; stall_tx only gates raising.
          m_valid_d = m_valid_q || !stall_tx;
        end
      end

      RECV: begin
        if (rx_hs) begin
          res_d[rx_cnt_q] = result_t'(r_data);
          ovf_d[rx_cnt_q] = r_ovf;
          if (rx_cnt_q == RX_LAST) begin
            state_d = DONE;
          end else begin
            rx_cnt_d = rx_cnt_q + KW'(1);
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d  = SEND;
          tx_cnt_d = '0;
          for (int i = 0; i < K; i++) begin
            res_d[i] = '0;
          end
          ovf_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      m_valid_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        res_q[i] <= '0;
      end
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      m_valid_q <= m_valid_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_valid = m_valid_q;
  assign rd_data = res_q[rd_addr];
  assign rd_ovf  = ovf_q[rd_addr];
  assign busy    = (state_q == SEND) || (state_q == RECV);
  assign done    = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mvma_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvma_stream_feeder
//  Description : Self-checking bench for mvma_stream_feeder. A monitor
//                compares every accepted operand against the frame the
//                bench wrote and a responder returns chosen result words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvma_stream_feeder;
  import mvma_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          stall_tx = 1'b0;
  logic          stall_rx = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [OW-1:0] r_data = '0;
  logic          r_ovf = 1'b0;
  logic [KW-1:0] rd_addr = '0;
  logic [OW-1:0] rd_data;
  logic          rd_ovf;
  logic          busy;
  logic          done;

  mvma_stream_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .stall_tx (stall_tx),
    .stall_rx (stall_rx),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_data   (r_data),
    .r_ovf    (r_ovf),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ovf   (rd_ovf),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the frame as the host wrote it, and the results to return.
  logic [DW-1:0] frame     [FL];
  logic [OW-1:0] resp_data [K];
  logic          resp_ovf  [K];

  // Monitor counters only ever increase; the main flow snapshots bases.
  int tx_idx = 0, tx_base = 0;
  int rx_idx = 0, rx_base = 0;
  int cyc = 0, mv_first = 0, mv_last = 0;
  int m_rel, r_rel;
  bit drv_en = 1'b0, resp_en = 1'b0, rnd_mode = 1'b0;
  bit pend = 1'b0, chk_done = 1'b0, prev_mv = 1'b0;
  logic [DW-1:0] pend_data = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: everything sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      pend     = 1'b0;
      chk_done = 1'b0;
      prev_mv  = 1'b0;
    end else begin
      if (chk_done) begin
        chk("done_latency", done, 1);
        chk_done = 1'b0;
      end
      if (pend) begin
        chk("mv_hold", m_valid, 1);
        chk("md_hold", m_data, pend_data);
      end
      if (stall_rx) chk("rready_stall", r_ready, 0);
      if (m_valid) begin
        chk("mv_only_busy", busy, 1);
        if (!prev_mv) mv_first = cyc;
        mv_last = cyc;
      end
      if (m_valid && m_ready) begin
        m_rel = tx_idx - tx_base;
        if (m_rel < FL) chk($sformatf("m_data[%0d]", m_rel), m_data, frame[m_rel]);
        tx_idx++;
      end
      if (r_valid && r_ready) begin
        rx_idx++;
        if (rx_idx - rx_base == K) begin
          chk("done_early", done, 0);
          chk_done = 1'b1;
        end
      end
      pend      = m_valid && !m_ready;
      pend_data = m_data;
      prev_mv   = m_valid;
    end
  end

  // Throttles and result responder, driven just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drv_en) begin
        m_ready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        stall_tx = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        stall_rx = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (resp_en) begin
        r_rel   = rx_idx - rx_base;
        r_valid = (r_rel < K) && (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        r_data  = (r_rel < K) ? resp_data[r_rel] : '0;
        r_ovf   = (r_rel < K) ? resp_ovf[r_rel] : 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic write_frame();
    for (int i = 0; i < FL; i++) begin
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = frame[i];
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < K; i++) begin
      rd_addr = KW'(i);
      #1;
      chk($sformatf("%s_rd[%0d]", tag, i), rd_data, resp_data[i]);
      chk($sformatf("%s_ovf[%0d]", tag, i), rd_ovf, resp_ovf[i]);
    end
  endtask

  task automatic readback_zero(input string tag);
    for (int i = 0; i < K; i++) begin
      rd_addr = KW'(i);
      #1;
      chk($sformatf("%s_rd[%0d]", tag, i), rd_data, 0);
      chk($sformatf("%s_ovf[%0d]", tag, i), rd_ovf, 0);
    end
  endtask

  task automatic run_frame(input bit rnd, input string tag);
    rnd_mode = rnd;
    tx_base  = tx_idx;
    rx_base  = rx_idx;
    drv_en   = 1'b1;
    resp_en  = 1'b1;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({tag, "_done_timeout"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_tx_count"}, tx_idx - tx_base, FL);
    chk({tag, "_rx_count"}, rx_idx - rx_base, K);
    resp_en = 1'b0;
    r_valid = 1'b0;
    readback(tag);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    readback_zero("rst");

    // r_valid in IDLE must not be acknowledged nor stored
    @(posedge clk);
    #1;
    r_valid = 1'b1;
    r_data  = 16'h1234;
    r_ovf   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_r_ready", r_ready, 0);
    end
    r_valid = 1'b0;
    r_ovf   = 1'b0;
    readback_zero("idle_rvalid");

    // Frame: M = identity, B = 1..4, X = 10..40
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        frame[r*K + c] = (r == c) ? 8'd1 : 8'd0;
    for (int i = 0; i < K; i++) begin
      frame[K*K + i]     = DW'(i + 1);
      frame[K*K + K + i] = DW'(10 * (i + 1));
    end
    write_frame();

    // Scenario 1: free-flowing, fixed results
    for (int i = 0; i < K; i++) begin
      resp_data[i] = OW'(11 * (i + 1));
      resp_ovf[i]  = 1'b0;
    end
    run_frame(1'b0, "s1");
    chk("s1_mv_consecutive", mv_last - mv_first + 1, FL);

    // Scenario 2: random throttles, random results
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < K; i++) begin
        resp_data[i] = OW'($urandom);
        resp_ovf[i]  = 1'($urandom_range(0, 1));
      end
      run_frame(1'b1, $sformatf("s2_%0d", rep));
    end

    // Scenario 3: saturated result with overflow on index 2 only
    for (int i = 0; i < K; i++) begin
      resp_data[i] = OW'($urandom);
      resp_ovf[i]  = 1'b0;
    end
    resp_data[2] = 16'h7FFF;
    resp_ovf[2]  = 1'b1;
    run_frame(1'b1, "s3");

    // Scenario 4: start and wr_en during SEND are ignored
    for (int i = 0; i < K; i++) begin
      resp_data[i] = OW'($urandom);
      resp_ovf[i]  = 1'b0;
    end
    fork
      run_frame(1'b0, "s4");
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (tx_idx - tx_base >= 3) break;
        end
        @(posedge clk);
        #1;
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
      end
    join
    run_frame(1'b1, "s4b");

    // Scenario 5: asynchronous reset mid-SEND, then a clean resend
    rnd_mode = 1'b0;
    tx_base  = tx_idx;
    rx_base  = rx_idx;
    drv_en   = 1'b1;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_idx - tx_base >= 10) break;
    end
    chk("s5_reached_10", (tx_idx - tx_base >= 10) ? 1 : 0, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("s5_async_m_valid", m_valid, 0);
    chk("s5_async_busy", busy, 0);
    chk("s5_async_done", done, 0);
    readback_zero("s5_rst");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < K; i++) begin
      resp_data[i] = OW'($urandom);
      resp_ovf[i]  = 1'($urandom_range(0, 1));
    end
    run_frame(1'b0, "s5");
    chk("s5_mv_consecutive", mv_last - mv_first + 1, FL);

    drv_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
